// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and constants for the systolic_array sequencer.
package systolic_pkg;

    localparam int OP_W  = 8;
    localparam int ACC_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } sc_state_t;

    // The last operand needs 2N-1 cycles after feeding ends to reach the
    // far corner PE of an N x N grid.
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_controller_if.sv
// systolic_controller_if: operand, array and result signals of the sequencer.
interface systolic_controller_if
    import systolic_pkg::*;
#(
    parameter int array_size = 3,
    parameter int k_width    = 8
) ();

    logic                          start;
    logic [k_width-1:0]            k_len;
    logic [OP_W*array_size-1:0]    a_vec;
    logic [OP_W*array_size-1:0]    b_vec;
    logic                          op_valid;
    logic                          op_ready;
    logic                          array_clear;
    logic [OP_W*array_size-1:0]    datain;
    logic [OP_W*array_size-1:0]    weightin;
    logic [ACC_W*array_size-1:0]   macouti;
    logic [ACC_W*array_size-1:0]   macoutj;
    logic [ACC_W*array_size-1:0]   res_i;
    logic [ACC_W*array_size-1:0]   res_j;
    logic                          busy;
    logic                          done;

    // Controller side
    modport slave (
        input  start, k_len, a_vec, b_vec, op_valid, macouti, macoutj,
        output op_ready, array_clear, datain, weightin, res_i, res_j, busy, done
    );

    // Operand-buffer / array / host side
    modport master (
        output start, k_len, a_vec, b_vec, op_valid, macouti, macoutj,
        input  op_ready, array_clear, datain, weightin, res_i, res_j, busy, done
    );

endinterface

// File: rtl/systolic_controller_skew_buffer.sv
// skew_buffer: diagonal skew for an N-lane operand vector. Every lane has an
// entry register; lane i then adds i further delay stages, so lane i leaves
// i cycles after lane 0.
module skew_buffer
    import systolic_pkg::*;
#(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W*N-1:0] din,
    output logic [OP_W*N-1:0] dout
);

    for (genvar lane = 0; lane < N; lane++) begin : g_lane
        logic [OP_W-1:0] pipe [lane+1];

        // Shift this lane's byte through its entry register and delay stages
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s <= lane; s++) begin
                    pipe[s] <= '0;
                end
            end else begin
                pipe[0] <= din[lane*OP_W +: OP_W];
                for (int s = 1; s <= lane; s++) begin
                    pipe[s] <= pipe[s-1];
                end
            end
        end

        assign dout[lane*OP_W +: OP_W] = pipe[lane];
    end

endmodule

// File: rtl/systolic_controller.sv
// systolic_controller: runs one tile through the output-stationary
// systolic_array -- clear, skewed feed, drain, result capture, done pulse.
module systolic_controller
    import systolic_pkg::*;
#(
    parameter int array_size = 3,
    parameter int k_width    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_controller_if.slave bus
);

    localparam int DRAIN_LEN = drain_cycles(array_size);
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);
    localparam int VEC_W     = OP_W * array_size;
    localparam int RES_W     = ACC_W * array_size;

    sc_state_t           state;
    sc_state_t           state_next;
    logic [k_width-1:0]  beat_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                drain_last;
    logic                transfer;
    logic                op_ready_c;
    logic                array_clear_c;
    logic                busy_c;
    logic                done_c;
    logic [VEC_W-1:0]    skew_a_in;
    logic [VEC_W-1:0]    skew_b_in;
    logic [VEC_W-1:0]    data_skewed;
    logic [VEC_W-1:0]    weight_skewed;
    logic [RES_W-1:0]    res_i_q;
    logic [RES_W-1:0]    res_j_q;

    assign drain_last = (drain_cnt == DRAIN_W'(DRAIN_LEN - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Beats still owed in this tile: loaded at start, decremented per transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          beat_cnt <= '0;
        else if (state == IDLE && bus.start) beat_cnt <= bus.k_len;
        else if (transfer)                   beat_cnt <= beat_cnt - 1'b1;
    end

    // Cycles spent in DRAIN so far; idles at zero in every other state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              drain_cnt <= '0;
        else if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
        else                     drain_cnt <= '0;
    end

    // Snapshot the edge accumulators once the last product has landed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_i_q <= '0;
            res_j_q <= '0;
        end else if (state == DRAIN && drain_last) begin
            res_i_q <= bus.macouti;
            res_j_q <= bus.macoutj;
        end
    end

    // Next-state logic and per-state outputs; a bubble or any non-FEED
    // state pushes zeros into the skew so accumulators stay unchanged
    always_comb begin
        state_next    = state;
        transfer      = 1'b0;
        op_ready_c    = 1'b0;
        array_clear_c = 1'b0;
        busy_c        = 1'b1;
        done_c        = 1'b0;
        skew_a_in     = '0;
        skew_b_in     = '0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.start) state_next = CLEAR;
            end
            CLEAR: begin
                array_clear_c = 1'b1;
                state_next    = (beat_cnt == '0) ? DRAIN : FEED;
            end
            FEED: begin
                op_ready_c = 1'b1;
                if (bus.op_valid) begin
                    transfer  = 1'b1;
                    skew_a_in = bus.a_vec;
                    skew_b_in = bus.b_vec;
                    if (beat_cnt == k_width'(1)) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last) state_next = DONE;
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    skew_buffer #(.N(array_size)) u_skew_data (
        .clk   (clk),
        .reset (reset),
        .din   (skew_a_in),
        .dout  (data_skewed)
    );

    skew_buffer #(.N(array_size)) u_skew_weight (
        .clk   (clk),
        .reset (reset),
        .din   (skew_b_in),
        .dout  (weight_skewed)
    );

    assign bus.op_ready    = op_ready_c;
    assign bus.array_clear = array_clear_c;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.datain      = data_skewed;
    assign bus.weightin    = weight_skewed;
    assign bus.res_i       = res_i_q;
    assign bus.res_j       = res_j_q;

endmodule

// File: tb/tb_systolic_controller.sv
// tb_systolic_controller: directed bench for systolic_controller (N=3) with a
// behavioural 3x3 output-stationary array closing the loop.
module tb_systolic_controller;
    import systolic_pkg::*;

    logic clk;
    logic reset;
    int   cyc;
    int   n_compared;
    int   n_mismatched;
    int   done_count;
    int   clear_count;
    int   ready_count;
    int   done_base;
    int   clear_base;
    int   ready_base;

    logic [23:0] exp_data   [5];
    logic [23:0] exp_weight [5];

    systolic_controller_if #(.array_size(3), .k_width(8)) sc_if ();

    systolic_controller #(.array_size(3), .k_width(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sc_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural array: PE(i,j) gets data from the left and weight from
    // above through one register per hop; its MAC output is acc + a*b.
    logic [7:0]  pe_a [3][2];
    logic [7:0]  pe_b [2][3];
    logic [7:0]  a_in [3][3];
    logic [7:0]  b_in [3][3];
    logic [15:0] acc  [3][3];
    logic [15:0] mac  [3][3];

    // Combinational PE inputs and MAC outputs, edge outputs to the controller
    always_comb begin
        a_in          = '{default: '0};
        b_in          = '{default: '0};
        mac           = '{default: '0};
        sc_if.macouti = '0;
        sc_if.macoutj = '0;
        for (int i = 0; i < 3; i++) begin
            a_in[i][0] = sc_if.datain[8*i +: 8];
            b_in[0][i] = sc_if.weightin[8*i +: 8];
            for (int j = 1; j < 3; j++) begin
                a_in[i][j] = pe_a[i][j-1];
                b_in[j][i] = pe_b[j-1][i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                mac[i][j] = acc[i][j] + ({8'd0, a_in[i][j]} * {8'd0, b_in[i][j]});
            end
        end
        for (int k = 0; k < 3; k++) begin
            sc_if.macouti[16*k +: 16] = mac[k][2];
            sc_if.macoutj[16*k +: 16] = mac[2][k];
        end
    end

    // Array registers: operand hops and accumulators, cleared by array_clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pe_a <= '{default: '0};
            pe_b <= '{default: '0};
            acc  <= '{default: '0};
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 2; j++) begin
                    pe_a[i][j] <= a_in[i][j];
                    pe_b[j][i] <= b_in[j][i];
                end
            end
            if (sc_if.array_clear) acc <= '{default: '0};
            else                   acc <= mac;
        end
    end

    // Event counters sampled mid-cycle
    initial begin
        done_count  = 0;
        clear_count = 0;
        ready_count = 0;
        forever begin
            @(negedge clk);
            if (sc_if.done === 1'b1)        done_count++;
            if (sc_if.array_clear === 1'b1) clear_count++;
            if (sc_if.op_ready === 1'b1)    ready_count++;
        end
    end

    // Hard stop in case the directed sequence itself stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic st, input logic [7:0] k,
                                  input logic [23:0] a, input logic [23:0] b,
                                  input logic valid);
        sc_if.start    = st;
        sc_if.k_len    = k;
        sc_if.a_vec    = a;
        sc_if.b_vec    = b;
        sc_if.op_valid = valid;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 40 && sc_if.done !== 1'b1; n++) step();
    endtask

    task automatic mark_tile();
        cyc        = 0;
        done_base  = done_count;
        clear_base = clear_count;
        ready_base = ready_count;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        cyc          = 0;
        exp_data   = '{24'h000000, 24'h000001, 24'h000200, 24'h030000, 24'h000000};
        exp_weight = '{24'h000000, 24'h000004, 24'h000500, 24'h060000, 24'h000000};
        reset = 1'b0;
        apply_stimulus(1'b0, 8'd0, 24'h0, 24'h0, 1'b0);

        // Reset values
        #2;
        check_output("rst_busy",     sc_if.busy,        0);
        check_output("rst_op_ready", sc_if.op_ready,    0);
        check_output("rst_clear",    sc_if.array_clear, 0);
        check_output("rst_done",     sc_if.done,        0);
        check_output("rst_datain",   sc_if.datain,      0);
        check_output("rst_weightin", sc_if.weightin,    0);
        check_output("rst_res_i",    sc_if.res_i,       0);
        check_output("rst_res_j",    sc_if.res_j,       0);
        #10;
        reset = 1'b1;
        step();

        // Basic tile: k_len=4, a lanes 1, b lanes 2, no bubbles
        mark_tile();
        apply_stimulus(1'b1, 8'd4, 24'h010101, 24'h020202, 1'b1);
        step();
        check_output("basic_c1_busy",  sc_if.busy,        1);
        check_output("basic_c1_clear", sc_if.array_clear, 1);
        check_output("basic_c1_ready", sc_if.op_ready,    0);
        apply_stimulus(1'b0, 8'd0, 24'h010101, 24'h020202, 1'b1);
        step();
        check_output("basic_c2_ready", sc_if.op_ready,    1);
        check_output("basic_c2_clear", sc_if.array_clear, 0);
        wait_done();
        check_output("basic_done_cycle", cyc, 11);
        check_output("basic_res_i", sc_if.res_i, 48'h0008_0008_0008);
        check_output("basic_res_j", sc_if.res_j, 48'h0008_0008_0008);
        step();
        check_output("basic_c12_busy", sc_if.busy, 0);
        check_output("basic_c12_done", sc_if.done, 0);
        check_output("basic_done_pulses", done_count - done_base, 1);

        // Skew: single beat a={3,2,1}, b={6,5,4}; start right after done
        mark_tile();
        apply_stimulus(1'b1, 8'd1, 24'h030201, 24'h060504, 1'b1);
        step();
        apply_stimulus(1'b0, 8'd0, 24'h030201, 24'h060504, 1'b1);
        for (int c = 2; c <= 6; c++) begin
            step();
            if (cyc == 3) sc_if.op_valid = 1'b0;
            check_output($sformatf("skew_datain_c%0d", c),   sc_if.datain,   exp_data[c-2]);
            check_output($sformatf("skew_weightin_c%0d", c), sc_if.weightin, exp_weight[c-2]);
        end
        wait_done();
        check_output("skew_done_cycle", cyc, 8);
        check_output("skew_res_i", sc_if.res_i, 48'h0012_000C_0006);
        check_output("skew_res_j", sc_if.res_j, 48'h0012_000F_000C);
        step();

        // Bubbles on beats 2 and 3 (op_valid low in cycles 3 and 4)
        mark_tile();
        apply_stimulus(1'b1, 8'd4, 24'h010101, 24'h020202, 1'b1);
        step();
        apply_stimulus(1'b0, 8'd0, 24'h010101, 24'h020202, 1'b1);
        step();
        step();
        sc_if.op_valid = 1'b0;
        step();
        check_output("bubble_c4_ready", sc_if.op_ready, 1);
        step();
        sc_if.op_valid = 1'b1;
        wait_done();
        check_output("bubble_done_cycle", cyc, 13);
        check_output("bubble_res_i", sc_if.res_i, 48'h0008_0008_0008);
        check_output("bubble_res_j", sc_if.res_j, 48'h0008_0008_0008);
        step();

        // Mid-tile reset in cycle 4, then a fresh tile
        mark_tile();
        apply_stimulus(1'b1, 8'd4, 24'h010101, 24'h020202, 1'b1);
        step();
        apply_stimulus(1'b0, 8'd0, 24'h010101, 24'h020202, 1'b1);
        repeat (3) step();
        check_output("midrst_c4_datain", sc_if.datain, 24'h000101);
        #3;
        reset = 1'b0;
        #1;
        check_output("midrst_busy",     sc_if.busy,     0);
        check_output("midrst_op_ready", sc_if.op_ready, 0);
        check_output("midrst_datain",   sc_if.datain,   0);
        check_output("midrst_weightin", sc_if.weightin, 0);
        check_output("midrst_res_i",    sc_if.res_i,    0);
        check_output("midrst_res_j",    sc_if.res_j,    0);
        repeat (3) step();
        @(negedge clk);
        reset = 1'b1;
        repeat (20) step();
        check_output("midrst_no_done", done_count - done_base, 0);
        mark_tile();
        apply_stimulus(1'b1, 8'd4, 24'h010101, 24'h020202, 1'b1);
        step();
        apply_stimulus(1'b0, 8'd0, 24'h010101, 24'h020202, 1'b1);
        wait_done();
        check_output("after_rst_done_cycle", cyc, 11);
        check_output("after_rst_res_i", sc_if.res_i, 48'h0008_0008_0008);
        step();

        // Zero length tile
        mark_tile();
        apply_stimulus(1'b1, 8'd0, 24'h010101, 24'h020202, 1'b1);
        step();
        apply_stimulus(1'b0, 8'd0, 24'h010101, 24'h020202, 1'b1);
        wait_done();
        check_output("zero_done_cycle", cyc, 7);
        check_output("zero_res_i", sc_if.res_i, 0);
        check_output("zero_res_j", sc_if.res_j, 0);
        step();
        check_output("zero_ready_cycles", ready_count - ready_base, 0);
        check_output("zero_clear_cycles", clear_count - clear_base, 1);

        // start pulsed during FEED is ignored
        mark_tile();
        apply_stimulus(1'b1, 8'd4, 24'h010101, 24'h020202, 1'b1);
        step();
        apply_stimulus(1'b0, 8'd0, 24'h010101, 24'h020202, 1'b1);
        step();
        step();
        sc_if.start = 1'b1;
        step();
        sc_if.start = 1'b0;
        wait_done();
        check_output("busystart_done_cycle", cyc, 11);
        repeat (20) step();
        check_output("busystart_done_pulses", done_count - done_base, 1);
        check_output("busystart_idle", sc_if.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
